// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and scan types for the VGA scan controller.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} scan_state_t;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_scan_controller_if.sv
// Plotter-facing and VGA-pin signals of the scan controller; master = controller.
interface vga_scan_if
  import vga_pkg::*;
#(
  parameter int CHAR_W = 8
) ();
  logic [CHAR_W-1:0] char_in;
  logic [CHAR_W-1:0] char_out;
  logic [11:0]       rgb_in;
  coord_t            rows;
  coord_t            columns;
  logic [3:0]        vga_r;
  logic [3:0]        vga_g;
  logic [3:0]        vga_b;
  logic              vga_hsync;
  logic              vga_vsync;
  logic              frame_start;

  modport master (
    input  char_in, rgb_in,
    output rows, columns, char_out, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start
  );

  modport slave (
    output char_in, rgb_in,
    input  rows, columns, char_out, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK region state.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS_LEN   = H_VISIBLE,
  parameter int FRONT_LEN = H_FRONT,
  parameter int SYNC_LEN  = H_SYNC,
  parameter int BACK_LEN  = H_BACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output coord_t      count,
  output scan_state_t state,
  output logic        wrap
);
  localparam coord_t FP_START   = coord_t'(VIS_LEN);
  localparam coord_t SYNC_START = coord_t'(VIS_LEN + FRONT_LEN);
  localparam coord_t BP_START   = coord_t'(VIS_LEN + FRONT_LEN + SYNC_LEN);
  localparam coord_t LAST       = coord_t'(VIS_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

  coord_t      count_d;
  scan_state_t state_d;

  assign wrap = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      state <= ACTIVE;
    end else begin
      count <= count_d;
      state <= state_d;
    end
  end

  // State is decoded from the next count so it always describes the count being output.
  always_comb begin
    count_d = count;
    state_d = state;
    if (advance) begin
      count_d = wrap ? '0 : count + 10'd1;
      if (count_d < FP_START)        state_d = ACTIVE;
      else if (count_d < SYNC_START) state_d = FRONT;
      else if (count_d < BP_START)   state_d = SYNC;
      else                           state_d = BACK;
    end
  end
endmodule

// File: rtl/vga_scan_controller.sv
// VGA 640x480@60 scan controller: pixel divider, H/V axes, 1-tick output pipeline, char hand-off.
// Build option: define SCAN_FRAME_LATCH_EN to update char_out only at frame start.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int PIX_DIV    = 2,
  parameter int CHAR_W     = 8,
  parameter int H_VIS_LEN  = H_VISIBLE,
  parameter int H_FP_LEN   = H_FRONT,
  parameter int H_SYNC_LEN = H_SYNC,
  parameter int H_BP_LEN   = H_BACK,
  parameter int V_VIS_LEN  = V_VISIBLE,
  parameter int V_FP_LEN   = V_FRONT,
  parameter int V_SYNC_LEN = V_SYNC,
  parameter int V_BP_LEN   = V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  vga_scan_if.master bus
);
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0]        div;
  logic              pix_tick;
  coord_t            h_cnt, v_cnt;
  scan_state_t       h_state, v_state;
  logic              h_wrap, v_wrap;
  logic [11:0]       rgb_q;
  logic              hsync_q, vsync_q, fs_q;
  logic [CHAR_W-1:0] char_q;

  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= pix_tick ? '0 : div + 4'd1;
  end

  vga_axis_counter #(
    .VIS_LEN(H_VIS_LEN), .FRONT_LEN(H_FP_LEN), .SYNC_LEN(H_SYNC_LEN), .BACK_LEN(H_BP_LEN)
  ) u_h (
    .clk(clk), .rst(rst), .advance(pix_tick),
    .count(h_cnt), .state(h_state), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VIS_LEN(V_VIS_LEN), .FRONT_LEN(V_FP_LEN), .SYNC_LEN(V_SYNC_LEN), .BACK_LEN(V_BP_LEN)
  ) u_v (
    .clk(clk), .rst(rst), .advance(pix_tick & h_wrap),
    .count(v_cnt), .state(v_state), .wrap(v_wrap)
  );

  // Syncs and colour are captured from the same coordinates so they stay aligned at the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= pix_tick & h_wrap & v_wrap;
      if (pix_tick) begin
        hsync_q <= (h_state != SYNC);
        vsync_q <= (v_state != SYNC);
        rgb_q   <= (h_state == ACTIVE && v_state == ACTIVE) ? bus.rgb_in : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_q <= '0;
`ifdef SCAN_FRAME_LATCH_EN
    else if (fs_q) char_q <= bus.char_in;
`else
    else char_q <= bus.char_in;
`endif
  end

  assign bus.rows        = v_cnt;
  assign bus.columns     = h_cnt;
  assign bus.char_out    = char_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller: full horizontal timing, shortened vertical timing.
module tb_vga_scan_controller;
  import vga_pkg::*;

  localparam int PIX_DIV = 2;
  localparam int CHAR_W  = 8;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3;
  localparam int LINE  = 800 * PIX_DIV;             // 1600 clks
  localparam int FRAME = LINE * (VV + VF + VS + VB); // 20800 clks

`ifdef SCAN_FRAME_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  vga_scan_if #(.CHAR_W(CHAR_W)) bus ();

  vga_scan_controller #(
    .PIX_DIV(PIX_DIV), .CHAR_W(CHAR_W),
    .V_VIS_LEN(VV), .V_FP_LEN(VF), .V_SYNC_LEN(VS), .V_BP_LEN(VB)
  ) dut (
    .clk(gclk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cols"},  32'(bus.columns), 0);
    chk({tag, "_rows"},  32'(bus.rows), 0);
    chk({tag, "_char"},  32'(bus.char_out), 0);
    chk({tag, "_rgb"},   32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
    chk({tag, "_hsync"}, 32'(bus.vga_hsync), 1);
    chk({tag, "_vsync"}, 32'(bus.vga_vsync), 1);
    chk({tag, "_fs"},    32'(bus.frame_start), 0);
  endtask

  initial begin
    int rf, gb, hs, hs0, vs, vs_first, vs_first_row, fs1, fs_idx, fs_all, hs_col, maxc, maxr;
    rf = 0; gb = 0; hs = 0; hs0 = 0; vs = 0; vs_first = 0; vs_first_row = 0;
    fs1 = 0; fs_idx = 0; fs_all = 0; hs_col = -1; maxc = 0; maxr = 0;
    bus.char_in = '0;
    bus.rgb_in  = 12'hF00;

    rst = 1'b1;
    repeat (3) @(negedge gclk);
    #1 chk_reset("rst");
    @(negedge gclk);
    rst = 1'b0;

    for (int i = 1; i <= 2 * FRAME + 1; i++) begin
      @(negedge gclk);
      if (bus.frame_start) fs_all++;
      if (i <= LINE) begin
        if (!bus.vga_hsync) hs0++;
        if (!bus.vga_hsync && hs_col < 0) hs_col = int'(bus.columns);
      end
      if (i <= FRAME) begin
        if (bus.vga_r == 4'hF) rf++;
        if ({bus.vga_g, bus.vga_b} != 8'h00) gb++;
        if (!bus.vga_hsync) hs++;
        if (!bus.vga_vsync) begin
          vs++;
          if (vs_first == 0) begin
            vs_first = i;
            vs_first_row = int'(bus.rows);
          end
        end
        if (bus.frame_start) begin
          fs1++;
          fs_idx = i;
        end
        if (int'(bus.columns) > maxc) maxc = int'(bus.columns);
        if (int'(bus.rows) > maxr) maxr = int'(bus.rows);
      end
      case (i)
        1: begin
          chk("tick1_cols", 32'(bus.columns), 0);
          chk("lat_pre_r", 32'(bus.vga_r), 0);
        end
        2: begin
          chk("tick2_cols", 32'(bus.columns), 1);
          chk("lat_post_r", 32'(bus.vga_r), 4'hF);
        end
        1599: begin
          chk("eol_cols", 32'(bus.columns), 799);
          chk("eol_rows", 32'(bus.rows), 0);
        end
        1600: begin
          chk("line_cols", 32'(bus.columns), 0);
          chk("line_rows", 32'(bus.rows), 1);
        end
        3200: begin
          chk("char_pre", 32'(bus.char_out), 0);
          bus.char_in = 8'h2D;
        end
        3201: chk("char_next", 32'(bus.char_out), LATCH ? 32'h00 : 32'h2D);
        FRAME: begin
          chk("fs_pulse", 32'(bus.frame_start), 1);
          chk("wrap_rows", 32'(bus.rows), 0);
          chk("wrap_cols", 32'(bus.columns), 0);
          chk("char_fs", 32'(bus.char_out), LATCH ? 32'h00 : 32'h2D);
        end
        FRAME + 1: begin
          chk("char_after_fs", 32'(bus.char_out), 32'h2D);
          chk("fs_one_clk", 32'(bus.frame_start), 0);
        end
        FRAME + 2 * LINE: bus.rgb_in = 12'h5A3;
        FRAME + 2 * LINE + 100: begin
          chk("rgb_5a3", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 12'h5A3);
          bus.rgb_in = 12'hF00;
        end
        FRAME + 7 * LINE + 100: chk("vblank_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        default: ;
      endcase
    end

    chk("hs_line_clks", 32'(hs0), 192);
    chk("hs_first_col", 32'(hs_col), 657);
    chk("r_active_clks", 32'(rf), 7680);
    chk("gb_nonzero", 32'(gb), 0);
    chk("hs_frame_clks", 32'(hs), 2496);
    chk("vs_frame_clks", 32'(vs), 3200);
    chk("vs_first_idx", 32'(vs_first), 12802);
    chk("vs_first_row", 32'(vs_first_row), 8);
    chk("fs_count1", 32'(fs1), 1);
    chk("fs_idx", 32'(fs_idx), FRAME);
    chk("fs_count2", 32'(fs_all), 2);
    chk("max_cols", 32'(maxc), 799);
    chk("max_rows", 32'(maxr), VV + VF + VS + VB - 1);

    // Walk to row 3, column 400 of the third frame and reset there.
    repeat (2 * FRAME + 3 * LINE + 800 - (2 * FRAME + 1)) @(negedge gclk);
    chk("mid_cols", 32'(bus.columns), 400);
    chk("mid_rows", 32'(bus.rows), 3);
    rst = 1'b1;
    #1 chk_reset("mid_rst");
    repeat (3) @(negedge gclk);
    chk_reset("mid_hold");
    rst = 1'b0;
    @(negedge gclk);
    chk("rel1_cols", 32'(bus.columns), 0);
    @(negedge gclk);
    chk("rel2_cols", 32'(bus.columns), 1);
    chk("rel2_r", 32'(bus.vga_r), 4'hF);
    fs_all = 0;
    repeat (3000) begin
      @(negedge gclk);
      if (bus.frame_start) fs_all++;
    end
    chk("no_fs_restart", 32'(fs_all), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
